// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
//   Control and address pins of the 16-bit asynchronous-SRAM interface.
//   The bidirectional data bus is not part of this bundle. It is a tristate
//   net that every party drives and resolves, so it stays a plain inout port
//   on the responder.
//
//   SRAM_ADDR  [17:0] word address
//   SRAM_WE_N         write enable, active low
//   SRAM_OE_N         output enable, active low
//   SRAM_CE_N         chip enable, active low
//   SRAM_UB_N         upper byte lane [15:8] enable, active low
//   SRAM_LB_N         lower byte lane [7:0] enable, active low
//
//   master : the memory controller driving the pins
//   slave  : the SRAM (or this responder) observing them
// -----------------------------------------------------------------------------
interface sram_responder_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  modport master (
    output SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   Stand-in for an external 16-bit asynchronous SRAM. It stores 16-bit words,
//   performs byte-lane writes while WE_N is low, and returns read data on
//   SRAM_DQ either combinationally (READ_LAT = 0) or READ_LAT clocks after the
//   address is presented. It also keeps access counters and a sticky
//   out-of-range flag.
//
//   Parameters
//     MEM_AW   implemented word-address bits (depth 2^MEM_AW words, < 18)
//     READ_LAT read latency in clocks, 0..3
//     CNT_W    width of the access counters
//
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     bus       SRAM control/address pins (slave side)
//     SRAM_DQ   bidirectional data bus, driven only during reads
//     wr_count  write cycles since reset (wraps)
//     rd_count  read accesses since reset (wraps)
//     addr_oob  sticky: an access used address bits above MEM_AW
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int MEM_AW   = 10,
  parameter int READ_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  sram_responder_if.slave     bus,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic                addr_oob
);

  localparam int DEPTH = 1 << MEM_AW;

  logic              sel;
  logic              wr;
  logic              rd;
  logic [MEM_AW-1:0] idx;
  logic              hi_addr;

  // WE_N low wins over OE_N low, which keeps wr and rd mutually exclusive.
  assign sel     = ~bus.SRAM_CE_N;
  assign wr      = sel & ~bus.SRAM_WE_N;
  assign rd      = sel &  bus.SRAM_WE_N & ~bus.SRAM_OE_N;
  assign idx     = bus.SRAM_ADDR[MEM_AW-1:0];
  assign hi_addr = |bus.SRAM_ADDR[17:MEM_AW];

  // Storage is never cleared. A write that coincides with rst is dropped.
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      if (!bus.SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
      if (!bus.SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Counters, sticky flag and previous-cycle read tracking.
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic             addr_oob_q, addr_oob_d;
  logic             prev_rd_q,  prev_rd_d;
  logic [17:0]      prev_addr_q, prev_addr_d;

  always_comb begin
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    addr_oob_d  = addr_oob_q;
    prev_rd_d   = rd;
    prev_addr_d = bus.SRAM_ADDR;
    if (wr) wr_count_d = wr_count_q + CNT_W'(1);
    // A read is one access per address; holding the same address across
    // cycles counts once.
    if (rd && (!prev_rd_q || (bus.SRAM_ADDR != prev_addr_q)))
      rd_count_d = rd_count_q + CNT_W'(1);
    if ((wr || rd) && hi_addr) addr_oob_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
      addr_oob_q <= 1'b0;
      // A read still held after reset counts as a fresh access.
      prev_rd_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      addr_oob_q <= addr_oob_d;
      prev_rd_q  <= prev_rd_d;
    end
    prev_addr_q <= prev_addr_d;
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
  assign addr_oob = addr_oob_q;

  // Read data path.
  logic [15:0] rdata;

  if (READ_LAT == 0) begin : g_lat0
    assign rdata = mem[idx];
  end else begin : g_latn
    // The output register captures on the edge that ends cycle c+READ_LAT-1
    // for a request made in cycle c, so the data is visible in cycle
    // c+READ_LAT. The tap is the request READ_LAT-1 cycles old.
    logic              tap_vld;
    logic [MEM_AW-1:0] tap_idx;
    logic [15:0]       out_q, out_d;

    if (READ_LAT == 1) begin : g_tap_pins
      assign tap_vld = rd;
      assign tap_idx = idx;
    end else begin : g_tap_pipe
      localparam int D = READ_LAT - 1;
      logic [D-1:0]      vld_q, vld_d;
      logic [MEM_AW-1:0] idx_q [D];
      logic [MEM_AW-1:0] idx_d [D];

      always_comb begin
        vld_d[0] = rd;
        idx_d[0] = idx;
        for (int i = 1; i < D; i++) begin
          vld_d[i] = vld_q[i-1];
          idx_d[i] = idx_q[i-1];
        end
      end

      // ---- stage boundary: pins -> request pipeline ----
      always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
        idx_q <= idx_d;
      end

      assign tap_vld = vld_q[D-1];
      assign tap_idx = idx_q[D-1];
    end

    always_comb begin
      out_d = out_q;
      if (tap_vld) out_d = mem[tap_idx];
    end

    // ---- stage boundary: request tap -> output register ----
    always_ff @(posedge clk) begin
      if (rst) out_q <= 16'h0000;
      else     out_q <= out_d;
    end

    assign rdata = out_q;
  end

  // Lanes are driven only during a read, only when enabled, never in reset.
  logic drv_hi, drv_lo;
  assign drv_hi = rd & ~rst & ~bus.SRAM_UB_N;
  assign drv_lo = rd & ~rst & ~bus.SRAM_LB_N;

  assign SRAM_DQ[15:8] = drv_hi ? rdata[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drv_lo ? rdata[7:0]  : 8'hzz;

endmodule
